// File: rtl/dma_stream_loader.sv
// Stream-to-line DMA loader: packs WORD_W-bit stream words into LINE_W-bit lines, one DMA write per line.
// Optional running checksum of accepted words when DMA_LOADER_CHECKSUM_EN is defined.
module dma_stream_loader #(
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_target,
    input  logic [ADDR_W-1:0] cmd_base_addr,
    input  logic [ADDR_W:0]   cmd_num_lines,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              dma_write_en,
    output logic [1:0]        dma_target,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [LINE_W-1:0] dma_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);
    localparam int WPL   = LINE_W / WORD_W;
    localparam int IDX_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WPL - 1);
    localparam logic [IDX_W-1:0]  ONE_IDX    = IDX_W'(1);
    localparam logic [ADDR_W:0]   ONE_CNT    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W+1:0] ADDR_LIMIT = {2'b01, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          target_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     num_q;
    logic [ADDR_W:0]     line_cnt_q;
    logic [IDX_W-1:0]    word_idx_q;
    logic [LINE_W-1:0]   line_buf_q, line_buf_d;
    logic                err_flag_q;
    logic                dma_we_q;
    logic [1:0]          dma_target_q;
    logic [ADDR_W-1:0]   dma_addr_q;
    logic [LINE_W-1:0]   dma_wdata_q;

    logic                cmd_hs_s, word_hs_s, line_end_s, last_line_s, reject_s;
    logic [ADDR_W+1:0]   addr_sum_s;

    // Range check done in ADDR_W+2 bits so base + count never wraps.
    assign addr_sum_s  = {2'b00, cmd_base_addr} + {1'b0, cmd_num_lines};
    assign reject_s    = (addr_sum_s > ADDR_LIMIT);
    assign cmd_hs_s    = cmd_valid && (state_q == S_IDLE);
    assign word_hs_s   = s_valid && (state_q == S_FILL);
    assign line_end_s  = word_hs_s && (word_idx_q == LAST_IDX);
    assign last_line_s = (line_cnt_q == (num_q - ONE_CNT));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_num_lines == '0) || reject_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (line_end_s && last_line_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake/status outputs decoded from the state register
    always_comb begin
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_IDLE: cmd_ready = 1'b1;
            S_FILL: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
                err  = err_flag_q;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    // Current line with the accepted word dropped into its slot (word 0 least significant)
    always_comb begin
        line_buf_d = line_buf_q;
        for (int k = 0; k < WPL; k++) begin
            if (word_hs_s && (word_idx_q == IDX_W'(k))) begin
                line_buf_d[WORD_W*k +: WORD_W] = s_data;
            end else begin
                line_buf_d[WORD_W*k +: WORD_W] = line_buf_q[WORD_W*k +: WORD_W];
            end
        end
    end

    // Command latch, packing counters and registered DMA write port
    always_ff @(posedge clk) begin
        if (!reset) begin
            target_q     <= 2'd0;
            base_q       <= '0;
            num_q        <= '0;
            line_cnt_q   <= '0;
            word_idx_q   <= '0;
            line_buf_q   <= '0;
            err_flag_q   <= 1'b0;
            dma_we_q     <= 1'b0;
            dma_target_q <= 2'd0;
            dma_addr_q   <= '0;
            dma_wdata_q  <= '0;
        end else begin
            dma_we_q <= 1'b0;
            if (cmd_hs_s) begin
                target_q   <= cmd_target;
                base_q     <= cmd_base_addr;
                num_q      <= cmd_num_lines;
                line_cnt_q <= '0;
                word_idx_q <= '0;
                line_buf_q <= '0;
                err_flag_q <= reject_s;
            end else if (word_hs_s) begin
                line_buf_q <= line_buf_d;
                word_idx_q <= line_end_s ? '0 : (word_idx_q + ONE_IDX);
                if (line_end_s) begin
                    dma_we_q     <= 1'b1;
                    dma_target_q <= target_q;
                    dma_addr_q   <= base_q + line_cnt_q[ADDR_W-1:0];
                    dma_wdata_q  <= line_buf_d;
                    line_cnt_q   <= line_cnt_q + ONE_CNT;
                end
            end
        end
    end

    assign dma_write_en = dma_we_q;
    assign dma_target   = dma_target_q;
    assign dma_addr     = dma_addr_q;
    assign dma_wdata    = dma_wdata_q;

`ifdef DMA_LOADER_CHECKSUM_EN
    function automatic logic [31:0] word_to_sum(input logic [WORD_W-1:0] w);
        return 32'(w);
    endfunction

    logic [31:0] checksum_q;

    // Running sum of accepted words, cleared per command and held after completion
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum_q <= 32'd0;
        end else if (cmd_hs_s) begin
            checksum_q <= 32'd0;
        end else if (word_hs_s) begin
            checksum_q <= checksum_q + word_to_sum(s_data);
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_dma_stream_loader.sv
// Scoreboard bench for dma_stream_loader: directed plan scenarios plus randomized commands.
module tb_dma_stream_loader;
    localparam int SPAN = 32768;
`ifdef DMA_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]   tgt;
        logic [14:0]  addr;
        logic [255:0] data;
    } wr_t;
    typedef struct {
        logic        err;
        logic [31:0] csum;
    } dn_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_target = 2'd0;
    logic [14:0]  cmd_base_addr = 15'd0;
    logic [15:0]  cmd_num_lines = 16'd0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = 32'd0;
    logic         dma_write_en;
    logic [1:0]   dma_target;
    logic [14:0]  dma_addr;
    logic [255:0] dma_wdata;
    logic         busy, done, err;
    logic [31:0]  checksum;

    wr_t          exp_wr_q[$];
    dn_t          exp_dn_q[$];
    logic [31:0]  words[$];
    int           wr_cycles[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           stalls = 0;
    int           ready_seen = 0;
    int           accept_cyc = 0;
    bit           mon_en = 1'b0;

    dma_stream_loader dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
        .cmd_base_addr(cmd_base_addr), .cmd_num_lines(cmd_num_lines),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .dma_write_en(dma_write_en), .dma_target(dma_target), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .busy(busy), .done(done), .err(err), .checksum(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: a command either loads num lines of consecutive words or is refused
    task automatic push_expect(input logic [1:0] t, input int base, input int num, input int start,
                               input int lines, input bit push_done);
        bit          rej;
        logic [31:0] sum;
        logic [255:0] data;
        rej = (base + num > SPAN);
        sum = 32'd0;
        if (!rej && num > 0) begin
            for (int l = 0; l < lines; l++) begin
                data = '0;
                for (int k = 0; k < 8; k++) begin
                    data = data | (256'(words[start + 8*l + k]) << (32*k));
                end
                exp_wr_q.push_back('{t, 15'(base + l), data});
            end
            for (int i = 0; i < 8*num; i++) sum = sum + words[start + i];
        end
        if (push_done) exp_dn_q.push_back('{rej, CSUM_EN ? sum : 32'd0});
    endtask

    task automatic gen_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic issue_cmd(input logic [1:0] t, input int base, input int num);
        int k = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_target = t;
        cmd_base_addr = 15'(base);
        cmd_num_lines = 16'(num);
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("cmd_accept_in_time", (k < 100), 1'b1);
        accept_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // mode 0: gap-free, mode 1: valid toggles every cycle, other: random gaps
    task automatic stream(input int start, input int n, input int mode);
        int   i = 0;
        int   g = 0;
        logic v;
        while (i < n && g < 4000) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = (g % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            s_valid = v;
            s_data = words[start + i];
            if (cmd_ready) ready_seen++;
            if (v && !s_ready) stalls++;
            if (v && s_ready) i++;
            g++;
        end
        check("stream_completed", (i == n), 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1'b1);
    endtask

    // Monitor: pops the scoreboard on every write and completion pulse
    always @(negedge clk) begin
        if (mon_en) begin
            check("cmd_ready_vs_busy", cmd_ready, !busy);
            check("err_only_with_done", (err && !done), 1'b0);
            if (dma_write_en) begin
                wr_cycles.push_back(cyc);
                check("write_expected", (exp_wr_q.size() != 0), 1'b1);
                if (exp_wr_q.size() != 0) begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    check("dma_target", dma_target, e.tgt);
                    check("dma_addr", dma_addr, e.addr);
                    check("dma_wdata", dma_wdata, e.data);
                end
            end
            if (done) begin
                check("done_expected", (exp_dn_q.size() != 0), 1'b1);
                if (exp_dn_q.size() != 0) begin
                    dn_t d;
                    d = exp_dn_q.pop_front();
                    check("done_err", err, d.err);
                    check("done_checksum", checksum, d.csum);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, base, num, mode;
        bit rej;
        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_write_en", dma_write_en, 1'b0);
        check("rst_addr", dma_addr, 15'd0);
        check("rst_wdata", dma_wdata, 256'd0);
        check("rst_target", dma_target, 2'd0);
        check("rst_checksum", checksum, 32'd0);
        mon_en = 1'b1;
        reset = 1'b1;

        // Single line, words 0..7
        words.delete();
        for (int i = 0; i < 8; i++) words.push_back(32'(i));
        push_expect(2'd2, 'h10, 1, 0, 1, 1'b1);
        issue_cmd(2'd2, 'h10, 1);
        stream(0, 8, 0);
        check("single_write_with_done", {dma_write_en, done}, 2'b11);
        check("single_checksum", checksum, CSUM_EN ? 32'd28 : 32'd0);
        check("single_wdata_const", dma_wdata, {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0});
        @(negedge clk);

        // Throughput: 4 lines gap-free
        gen_words(32);
        stalls = 0;
        wr_cycles.delete();
        push_expect(2'd0, 0, 4, 0, 4, 1'b1);
        issue_cmd(2'd0, 0, 4);
        stream(0, 32, 0);
        check("thru_last_write_with_done", {dma_write_en, done}, 2'b11);
        @(negedge clk);
        check("thru_no_stall", stalls, 0);
        check("thru_write_count", wr_cycles.size(), 4);
        for (int i = 1; i < wr_cycles.size(); i++)
            check("thru_spacing", wr_cycles[i] - wr_cycles[i-1], 8);

        // Toggling valid: 2 lines, 16 cycles apart
        gen_words(16);
        wr_cycles.delete();
        push_expect(2'd1, 'h123, 2, 0, 2, 1'b1);
        issue_cmd(2'd1, 'h123, 2);
        stream(0, 16, 1);
        wait_done();
        @(negedge clk);
        check("stall_write_count", wr_cycles.size(), 2);
        if (wr_cycles.size() == 2) check("stall_spacing", wr_cycles[1] - wr_cycles[0], 16);

        // Top address accepted
        gen_words(8);
        push_expect(2'd3, 'h7FFF, 1, 0, 1, 1'b1);
        issue_cmd(2'd3, 'h7FFF, 1);
        stream(0, 8, 0);
        check("top_write_done", {dma_write_en, done, err}, 3'b110);

        // Overflowing range rejected one cycle after accept
        push_expect(2'd0, 'h7FFF, 2, 0, 2, 1'b1);
        issue_cmd(2'd0, 'h7FFF, 2);
        check("reject_done_err", {done, err, dma_write_en}, 3'b110);
        check("reject_latency", cyc - accept_cyc, 1);

        // Zero-length command
        push_expect(2'd1, 'h40, 0, 0, 0, 1'b1);
        issue_cmd(2'd1, 'h40, 0);
        check("zero_done_no_err", {done, err, dma_write_en}, 3'b100);

        // Maximum count with nonzero base rejected
        push_expect(2'd2, 1, 32768, 0, 0, 1'b1);
        issue_cmd(2'd2, 1, 32768);
        check("maxcount_reject", {done, err}, 2'b11);

        // Reset after 5 words of line 2 of 3
        gen_words(24);
        push_expect(2'd2, 'h500, 3, 0, 1, 1'b0);
        issue_cmd(2'd2, 'h500, 3);
        stream(0, 13, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_state", {busy, dma_write_en, cmd_ready, s_ready}, 4'b0010);
        check("midrst_checksum", checksum, 32'd0);
        reset = 1'b1;
        check("midrst_no_pending", exp_wr_q.size(), 0);
        gen_words(8);
        push_expect(2'd1, 'h501, 1, 0, 1, 1'b1);
        issue_cmd(2'd1, 'h501, 1);
        stream(0, 8, 0);
        wait_done();
        @(negedge clk);

        // Busy lockout: second command held on cmd_valid during a 2-line load
        gen_words(24);
        push_expect(2'd2, 100, 2, 0, 2, 1'b1);
        push_expect(2'd3, 200, 1, 16, 1, 1'b1);
        issue_cmd(2'd2, 100, 2);
        cmd_valid = 1'b1;
        cmd_target = 2'd3;
        cmd_base_addr = 15'd200;
        cmd_num_lines = 16'd1;
        ready_seen = 0;
        stream(0, 16, 0);
        check("lock_done", done, 1'b1);
        check("lock_ready_low_at_done", cmd_ready, 1'b0);
        check("lock_ready_low_in_fill", ready_seen, 0);
        @(negedge clk);
        check("lock_ready_after_done", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("lock_second_accepted", {busy, s_ready}, 2'b11);
        stream(16, 8, 0);
        wait_done();
        @(negedge clk);

        // Randomized commands
        for (int it = 0; it < 20; it++) begin
            t = $urandom_range(0, 3);
            num = $urandom_range(0, 3);
            base = ($urandom_range(0, 3) == 0) ? (SPAN - $urandom_range(0, 4)) : $urandom_range(0, SPAN - 1);
            if (base > SPAN - 1) base = SPAN - 1;
            mode = $urandom_range(0, 2);
            rej = (base + num > SPAN);
            gen_words(8*num);
            push_expect(2'(t), base, num, 0, num, 1'b1);
            issue_cmd(2'(t), base, num);
            if (num > 0 && !rej) stream(0, 8*num, mode);
            wait_done();
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("all_writes_seen", exp_wr_q.size(), 0);
        check("all_dones_seen", exp_dn_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
